// File: rtl/step_size_controller.sv
`default_nettype none
// ============================================================================
// Module   : step_size_controller
// Summary  : Windowed mean-|error| monitor and convergence FSM that picks the
//            adaptive filter's step size: coarse (ADAPT), fine (FINE) or
//            frozen at zero (DIVERGED).
// Option   : define STEP_CTRL_AUTO_RECOVER_EN to leave DIVERGED on its own
//            after RECOVER_WINS completed windows.
// Revision : 1.0 - initial release
// ============================================================================
module step_size_controller #(
  parameter int               WIDTH        = 32,
  parameter int               FRAC         = 20,
  parameter int               LOG2_WIN     = 4,
  parameter logic [WIDTH-1:0] STEP_INIT    = WIDTH'(32'h0000_0400),
  parameter int               FINE_SHIFT   = 2,
  parameter int               CONV_WINS    = 2,
  parameter int               RECOVER_WINS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_error,
  input  logic             i_ovr,
  input  logic [WIDTH-1:0] i_conv_thresh,
  input  logic [WIDTH-1:0] i_div_thresh,
  input  logic             i_restart,
  output logic [WIDTH-1:0] o_step_size,
  output logic [WIDTH-1:0] o_mean_err,
  output logic             o_mean_valid,
  output logic [1:0]       o_state,
  output logic             o_diverged
);

  localparam int               ACC_W     = WIDTH - 1 + LOG2_WIN;
  localparam int               GOOD_W    = $clog2(CONV_WINS + 1);
  localparam logic [WIDTH-1:0] STEP_FINE = STEP_INIT >> FINE_SHIFT;

  typedef enum logic [1:0] {
    ADAPT    = 2'd0,
    FINE     = 2'd1,
    DIVERGED = 2'd2
  } state_t;

  // Parameter sanity checks at elaboration time
  if (LOG2_WIN < 1) begin : g_chk_win
    $error("LOG2_WIN must be at least 1");
  end
  if (CONV_WINS < 1) begin : g_chk_conv
    $error("CONV_WINS must be at least 1");
  end
  if (RECOVER_WINS < 1) begin : g_chk_recover
    $error("RECOVER_WINS must be at least 1");
  end
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_chk_frac
    $error("FRAC must lie within the sample width");
  end

  state_t              state;
  state_t              state_next;
  logic [ACC_W-1:0]    acc;
  logic [LOG2_WIN-1:0] cnt;
  logic                ovr_seen;
  logic [GOOD_W-1:0]   good_cnt;
  logic [GOOD_W-1:0]   good_next;
  logic [GOOD_W-1:0]   good_inc;

`ifdef STEP_CTRL_AUTO_RECOVER_EN
  localparam int REC_W = $clog2(RECOVER_WINS + 1);
  logic [REC_W-1:0] recover_cnt;
  logic [REC_W-1:0] recover_next;
  logic [REC_W-1:0] recover_inc;
`endif

  logic [WIDTH-2:0]    abs_err;
  logic [ACC_W-1:0]    sum;
  logic [WIDTH-1:0]    mean;
  logic                win_end;
  logic                ovr_now;
  logic                bad;
  logic                good;

  // Magnitude of the signed error; the most negative code has no positive
  // twin in WIDTH-1 bits and saturates to the largest magnitude instead.
  always_comb begin
    if (!i_error[WIDTH-1]) begin
      abs_err = i_error[WIDTH-2:0];
    end else if (i_error[WIDTH-2:0] == '0) begin
      abs_err = '1;
    end else begin
      abs_err = ~i_error[WIDTH-2:0] + (WIDTH-1)'(1);
    end
  end

  // Window arithmetic and the per-window quality verdict
  always_comb begin
    sum      = acc + {{LOG2_WIN{1'b0}}, abs_err};
    mean     = WIDTH'(sum >> LOG2_WIN);
    win_end  = i_valid && (cnt == '1);
    ovr_now  = ovr_seen | i_ovr;
    bad      = ovr_now || (mean > i_div_thresh);
    good     = mean < i_conv_thresh;
    good_inc = good_cnt + GOOD_W'(1);
  end

  // Convergence decisions, taken only on a window-end sample
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
`ifdef STEP_CTRL_AUTO_RECOVER_EN
    recover_next = recover_cnt;
    recover_inc  = recover_cnt + REC_W'(1);
`endif
    if (win_end) begin
      case (state)
        ADAPT: begin
          if (bad) begin
            state_next = DIVERGED;
            good_next  = '0;
`ifdef STEP_CTRL_AUTO_RECOVER_EN
            recover_next = '0;
`endif
          end else if (good) begin
            if (good_inc == GOOD_W'(CONV_WINS)) begin
              state_next = FINE;
              good_next  = '0;
            end else begin
              good_next = good_inc;
            end
          end else begin
            good_next = '0;
          end
        end
        FINE: begin
          good_next = '0;
          if (bad) begin
            state_next = DIVERGED;
`ifdef STEP_CTRL_AUTO_RECOVER_EN
            recover_next = '0;
`endif
          end else if (!good) begin
            state_next = ADAPT;
          end
        end
        DIVERGED: begin
`ifdef STEP_CTRL_AUTO_RECOVER_EN
          if (recover_inc == REC_W'(RECOVER_WINS)) begin
            state_next   = ADAPT;
            good_next    = '0;
            recover_next = '0;
          end else begin
            recover_next = recover_inc;
          end
`endif
        end
        default: begin
          state_next = ADAPT;
          good_next  = '0;
        end
      endcase
    end
  end

  // Step value associated with each convergence state
  function automatic logic [WIDTH-1:0] step_for(input state_t s);
    case (s)
      ADAPT:   step_for = STEP_INIT;
      FINE:    step_for = STEP_FINE;
      default: step_for = '0;
    endcase
  endfunction

  // Window accumulation, FSM state and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ADAPT;
      acc          <= '0;
      cnt          <= '0;
      ovr_seen     <= 1'b0;
      good_cnt     <= '0;
`ifdef STEP_CTRL_AUTO_RECOVER_EN
      recover_cnt  <= '0;
`endif
      o_step_size  <= STEP_INIT;
      o_mean_err   <= '0;
      o_mean_valid <= 1'b0;
      o_state      <= ADAPT;
      o_diverged   <= 1'b0;
    end else if (i_restart) begin
      // Restart wins over any coincident sample, window-end included
      state        <= ADAPT;
      acc          <= '0;
      cnt          <= '0;
      ovr_seen     <= 1'b0;
      good_cnt     <= '0;
`ifdef STEP_CTRL_AUTO_RECOVER_EN
      recover_cnt  <= '0;
`endif
      o_step_size  <= STEP_INIT;
      o_mean_valid <= 1'b0;
      o_state      <= ADAPT;
      o_diverged   <= 1'b0;
    end else begin
      o_mean_valid <= win_end;
      if (i_valid) begin
        if (win_end) begin
          acc        <= '0;
          cnt        <= '0;
          ovr_seen   <= 1'b0;
          o_mean_err <= mean;
        end else begin
          acc      <= sum;
          cnt      <= cnt + LOG2_WIN'(1);
          ovr_seen <= ovr_now;
        end
      end
      state       <= state_next;
      good_cnt    <= good_next;
`ifdef STEP_CTRL_AUTO_RECOVER_EN
      recover_cnt <= recover_next;
`endif
      o_step_size <= step_for(state_next);
      o_state     <= state_next;
      o_diverged  <= (state_next == DIVERGED);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_size_controller.sv
`timescale 1ns/1ps
module tb_step_size_controller;
  localparam int WIN     = 4;
  localparam int CONV    = 2;
  localparam int RECOVER = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_error = '0;
  logic        i_ovr = 1'b0;
  logic [31:0] i_conv_thresh = 32'h0000_2000;
  logic [31:0] i_div_thresh  = 32'h1000_0000;
  logic        i_restart = 1'b0;
  logic [31:0] o_step_size;
  logic [31:0] o_mean_err;
  logic        o_mean_valid;
  logic [1:0]  o_state;
  logic        o_diverged;

  int total = 0;
  int bad   = 0;

  step_size_controller #(
    .WIDTH(32), .FRAC(20), .LOG2_WIN(2), .STEP_INIT(32'h0000_0400),
    .FINE_SHIFT(2), .CONV_WINS(CONV), .RECOVER_WINS(RECOVER)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_error(i_error), .i_ovr(i_ovr),
    .i_conv_thresh(i_conv_thresh), .i_div_thresh(i_div_thresh),
    .i_restart(i_restart), .o_step_size(o_step_size), .o_mean_err(o_mean_err),
    .o_mean_valid(o_mean_valid), .o_state(o_state), .o_diverged(o_diverged)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state: 0 ADAPT, 1 FINE, 2 DIVERGED
  int          m_state = 0;
  int          m_samples = 0;
  longint      m_total = 0;
  bit          m_ovr = 1'b0;
  int          m_good_run = 0;
  int          m_div_windows = 0;
  logic [31:0] m_mean = '0;
  bit          m_mv = 1'b0;

  function automatic longint magnitude(input logic [31:0] e);
    longint v;
    v = longint'($signed(e));
    if (v < 0) v = -v;
    if (v > 64'h7FFF_FFFF) v = 64'h7FFF_FFFF;
    return v;
  endfunction

  function automatic logic [31:0] step_of(input int st);
    if (st == 0) return 32'h400;
    if (st == 1) return 32'h100;
    return 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit w_bad, w_good;
    if (rst) begin
      m_state = 0; m_samples = 0; m_total = 0; m_ovr = 0;
      m_good_run = 0; m_div_windows = 0; m_mean = '0; m_mv = 0;
    end else begin
      m_mv = 0;
      if (i_restart) begin
        m_state = 0; m_samples = 0; m_total = 0; m_ovr = 0;
        m_good_run = 0; m_div_windows = 0;
      end else if (i_valid) begin
        m_total   += magnitude(i_error);
        m_ovr     |= i_ovr;
        m_samples += 1;
        if (m_samples == WIN) begin
          m_mean = 32'(m_total / WIN);
          m_mv   = 1;
          w_bad  = m_ovr || (m_mean > i_div_thresh);
          w_good = m_mean < i_conv_thresh;
          if (m_state == 0) begin
            if (w_bad) begin
              m_state = 2; m_div_windows = 0; m_good_run = 0;
            end else if (w_good) begin
              m_good_run++;
              if (m_good_run >= CONV) begin m_state = 1; m_good_run = 0; end
            end else m_good_run = 0;
          end else if (m_state == 1) begin
            if (w_bad) begin m_state = 2; m_div_windows = 0; end
            else if (!w_good) m_state = 0;
          end else begin
`ifdef STEP_CTRL_AUTO_RECOVER_EN
            m_div_windows++;
            if (m_div_windows >= RECOVER) begin
              m_state = 0; m_good_run = 0; m_div_windows = 0;
            end
`endif
          end
          m_samples = 0; m_total = 0; m_ovr = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("mean_valid", {31'b0, o_mean_valid}, {31'b0, m_mv});
    check("mean_err",   o_mean_err, m_mean);
    check("state",      {30'b0, o_state}, 32'(m_state));
    check("step_size",  o_step_size, step_of(m_state));
    check("diverged",   {31'b0, o_diverged}, {31'b0, (m_state == 2)});
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] e, input logic o, input logic r);
    @(negedge clk); #1;
    i_valid = v; i_error = e; i_ovr = o; i_restart = r;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic window(input logic [31:0] e);
    repeat (WIN) drive(1'b1, e, 1'b0, 1'b0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", {30'b0, o_state}, 32'h0);
    check("rst_step",  o_step_size, 32'h400);
    check("rst_mean",  o_mean_err, 32'h0);
    check("rst_mv",    {31'b0, o_mean_valid}, 32'h0);
    check("rst_div",   {31'b0, o_diverged}, 32'h0);
    #1 rst = 1'b0;

    // First good window, with a gap in the middle
    drive(1, 32'h1000, 0, 0); drive(1, 32'h1000, 0, 0); idle();
    drive(1, 32'h1000, 0, 0); drive(1, 32'h1000, 0, 0); idle();
    check("w1_mean",  o_mean_err, 32'h1000);
    check("w1_mv",    {31'b0, o_mean_valid}, 32'h1);
    check("w1_state", {30'b0, o_state}, 32'h0);
    // Second good window -> FINE
    window(32'h1000);
    check("w2_state", {30'b0, o_state}, 32'h1);
    check("w2_step",  o_step_size, 32'h100);

    // Mediocre window from FINE -> ADAPT
    window(32'hFFFF_D000);
    check("w3_mean",  o_mean_err, 32'h3000);
    check("w3_state", {30'b0, o_state}, 32'h0);
    check("w3_step",  o_step_size, 32'h400);

    // Overflow on sample 2 -> DIVERGED
    drive(1, 32'h10, 0, 0); drive(1, 32'h10, 1, 0);
    drive(1, 32'h10, 0, 0); drive(1, 32'h10, 0, 0); idle();
    check("ovr_state", {30'b0, o_state}, 32'h2);
    check("ovr_step",  o_step_size, 32'h0);
    check("ovr_div",   {31'b0, o_diverged}, 32'h1);

    // Restart out of DIVERGED
    drive(0, 32'h0, 0, 1); idle();
    check("rs_state", {30'b0, o_state}, 32'h0);
    check("rs_step",  o_step_size, 32'h400);

    // Most negative samples saturate, mean above divergence threshold
    window(32'h8000_0000);
    check("sat_mean",  o_mean_err, 32'h7FFF_FFFF);
    check("sat_state", {30'b0, o_state}, 32'h2);

    // Restart coincident with a window-end sample discards it
    drive(0, 32'h0, 0, 1);
    drive(1, 32'h100, 0, 0); drive(1, 32'h100, 0, 0); drive(1, 32'h100, 0, 0);
    drive(1, 32'h100, 0, 1); idle();
    check("rsw_mv",    {31'b0, o_mean_valid}, 32'h0);
    check("rsw_state", {30'b0, o_state}, 32'h0);
    window(32'h200);
    check("fresh_mean",  o_mean_err, 32'h200);
    check("fresh_state", {30'b0, o_state}, 32'h0);

    // Reset mid-window drops partial data and the good-window run
    drive(1, 32'h5000, 0, 0); drive(1, 32'h5000, 0, 0);
    @(negedge clk); #1 rst = 1'b1; i_valid = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    check("mrst_mean", o_mean_err, 32'h0);
    window(32'h40);
    check("mrst_w_mean",  o_mean_err, 32'h40);
    check("mrst_w_state", {30'b0, o_state}, 32'h0);
    window(32'h40);
    check("mrst_fine", {30'b0, o_state}, 32'h1);

    // Divergence from FINE, then recovery behaviour
    drive(1, 32'h10, 1, 0); drive(1, 32'h10, 0, 0);
    drive(1, 32'h10, 0, 0); drive(1, 32'h10, 0, 0); idle();
    check("fdiv_state", {30'b0, o_state}, 32'h2);
    repeat (3) window(32'h10);
    check("hold_state", {30'b0, o_state}, 32'h2);
    window(32'h10);
`ifdef STEP_CTRL_AUTO_RECOVER_EN
    check("rec_state", {30'b0, o_state}, 32'h0);
    check("rec_step",  o_step_size, 32'h400);
`else
    check("rec_state", {30'b0, o_state}, 32'h2);
    check("rec_step",  o_step_size, 32'h0);
`endif
    window(32'h10);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_size_controller.md
# step_size_controller

Adaptive step-size controller that sits directly downstream of the adaptive filter and closes the loop back into its step-size input. It consumes the per-sample error and overflow flag, averages the absolute error over fixed windows, and runs a convergence state machine that selects a coarse step, a fine step, or zero (frozen) step. It also reports the windowed mean error for monitoring.

## Interface
Parameters:
- WIDTH, 32, sample/step width (signed error, unsigned step and thresholds, Q(WIDTH-FRAC).FRAC)
- FRAC, 20, fractional bits (shared with the filter)
- LOG2_WIN, 4, log2 of samples per averaging window (window N = 2^LOG2_WIN)
- STEP_INIT, 32'h0000_0400, coarse step used in ADAPT
- FINE_SHIFT, 2, fine step = STEP_INIT >> FINE_SHIFT
- CONV_WINS, 2, consecutive good windows required to enter FINE
- RECOVER_WINS, 4, windows spent in DIVERGED before auto-recovery (macro only)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  error sample strobe, one sample per high cycle
- i_error  in  WIDTH signed  filter error sample
- i_ovr  in  1  filter overflow for this sample
- i_conv_thresh  in  WIDTH  unsigned convergence threshold on mean |error|
- i_div_thresh  in  WIDTH  unsigned divergence threshold on mean |error|
- i_restart  in  1  synchronous restart pulse
- o_step_size  out  WIDTH  registered step for the filter
- o_mean_err  out  WIDTH  registered mean |error| of last window
- o_mean_valid  out  1  one-cycle pulse when o_mean_err updates
- o_state  out  2  0=ADAPT, 1=FINE, 2=DIVERGED
- o_diverged  out  1  high while in DIVERGED

## Operation
- Per valid sample: abs = |i_error|; 0x8000_0000-style most-negative value saturates to 2^(WIDTH-1)-1. Accumulate into unsigned accumulator of WIDTH-1+LOG2_WIN bits (cannot overflow). Sticky ovr_seen |= i_ovr.
- Sample counter counts 0..N-1; sample N-1 is window end. mean = (acc + abs) >> LOG2_WIN (fits WIDTH-1 bits). At window end: acc, counter, ovr_seen clear; o_mean_err = mean; o_mean_valid pulses. Thresholds sampled at window end only.
- bad = ovr_seen (incl. current sample) or mean > i_div_thresh; good = mean < i_conv_thresh.
- ADAPT (step STEP_INIT): bad -> DIVERGED; good -> good_cnt++, on reaching CONV_WINS -> FINE, good_cnt=0; else good_cnt=0.
- FINE (step STEP_INIT>>FINE_SHIFT): bad -> DIVERGED; not good -> ADAPT; good -> stay.
- DIVERGED (step 0, o_diverged=1): windows keep running and o_mean_valid keeps pulsing; exit only per Configuration or i_restart.
- i_restart (any state): next cycle ADAPT, acc/counter/ovr_seen/good_cnt/recover_cnt = 0, o_mean_valid=0; a coincident i_valid sample is discarded, including a window-end sample.
- o_step_size, o_state, o_diverged always consistent with registered state.

## Timing
- Reset: state ADAPT, o_step_size=STEP_INIT, o_mean_err=0, o_mean_valid=0, o_state=0, o_diverged=0, all counters 0.
- Window-end sample at cycle t -> o_mean_err, o_mean_valid, o_state, o_step_size updated at t+1 (one register stage).
- i_valid low cycles: no state change; gaps within a window allowed.
- i_restart at t -> ADAPT and STEP_INIT visible at t+1.
- Reset mid-window discards the partial window.

## Configuration
- STEP_CTRL_AUTO_RECOVER_EN defined: in DIVERGED, recover_cnt counts completed windows; on the RECOVER_WINS-th window end -> ADAPT with good_cnt=0, step STEP_INIT at t+1.
- Undefined: recover_cnt absent; DIVERGED held until i_restart or rst.

## Test plan
- LOG2_WIN=2, CONV_WINS=2, conv=0x2000: reset, 8 valid errors of 0x1000 -> o_mean_err=0x1000 pulses at samples 4 and 8; after second, o_state=1, o_step_size=0x100.
- From FINE, 4 errors of -0x3000 -> o_mean_err=0x3000, o_state=0, o_step_size=0x400.
- 4 errors 0x10 with i_ovr high on sample 2 -> o_state=2, o_step_size=0, o_diverged=1 one cycle after sample 4.
- 4 errors 0x8000_0000, div=0x1000_0000 -> o_mean_err=0x7FFF_FFFF, DIVERGED.
- i_restart coincident with window-end valid -> no o_mean_valid, ADAPT, next 4 samples form a fresh window.
- With STEP_CTRL_AUTO_RECOVER_EN, RECOVER_WINS=4: after divergence, 16 valid samples -> ADAPT, step 0x400; without macro, still DIVERGED.
